// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants for the write-port arbiter.
// REGWR_STARVE_GUARD_EN enables the requester-1 starvation guard.
package regfile_write_arbiter_pkg;
    localparam int RegisterNumLog2  = 5;
    localparam int RegisterBusWidth = 32;
    localparam int RegWrStarveLimit = 4;

    typedef logic [RegisterBusWidth-1:0] RegisterBus;
    typedef logic [RegisterNumLog2-1:0]  RegisterAddressBus;

    localparam RegisterBus ZeroWord    = '0;
    localparam logic       WriteEnable = 1'b1;
endpackage

// File: rtl/regfile_write_arbiter.sv
// Two-writer arbiter for the register-file write port, registered output.
// Define REGWR_STARVE_GUARD_EN to force a req1 grant after STARVE_LIMIT refusals.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = RegisterBusWidth,
    parameter int ADDR_WIDTH   = RegisterNumLog2,
    parameter int STARVE_LIMIT = RegWrStarveLimit
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy1
);

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_force1;
    logic                  w_grant0;
    logic                  w_grant1;

`ifdef REGWR_STARVE_GUARD_EN
    localparam int CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] r_starve;

    assign w_force1 = req1_valid && (r_starve == CntW'(STARVE_LIMIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_grant1 || !req1_valid) begin
            r_starve <= '0;
        end else if (r_starve != CntW'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_force1 = 1'b0;
`endif

    assign w_grant0 = !reset && req0_valid && !w_force1;
    assign w_grant1 = !reset && req1_valid && (!req0_valid || w_force1);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign busy1      = !reset && req1_valid && !w_grant1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_grant0) begin
            r_we   <= (req0_address != '0) ? WriteEnable : 1'b0;
            r_addr <= req0_address;
            r_data <= req0_data;
        end else if (w_grant1) begin
            r_we   <= (req1_address != '0) ? WriteEnable : 1'b0;
            r_addr <= req1_address;
            r_data <= req1_data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    // Reset must kill a write already sitting in the output stage.
    assign write_enable  = r_we && !reset;
    assign write_address = r_addr;
    assign write_data    = r_data;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writers: requester 0 (main pipeline write-back) and requester 1 (multi-cycle unit, e.g. divider or load return).
- Fixed priority to requester 0, with an optional starvation guard. Drives the register file's write_enable / write_address / write_data from a registered output stage.
- Its ready outputs act as the write-back stall sources for each requester.

Parameters:
- DATA_WIDTH, 32, width of write data (matches RegisterBus)
- ADDR_WIDTH, 5, register address width (matches RegisterNumLog2)
- STARVE_LIMIT, 4, consecutive cycles requester 1 may be refused before forced grant (guard build only)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_address  input  ADDR_WIDTH  requester 0 destination register
- req0_data  input  DATA_WIDTH  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_address  input  ADDR_WIDTH  requester 1 destination register
- req1_data  input  DATA_WIDTH  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- write_enable  output  1  to register file write enable
- write_address  output  ADDR_WIDTH  to register file write address
- write_data  output  DATA_WIDTH  to register file write data
- busy1  output  1  requester 1 refused this cycle (valid && !ready); debug/perf

Behaviour:
- Reset:
  - Active-high, synchronous, sampled on the clock edge.
  - While reset=1: req0_ready=0, req1_ready=0, busy1=0.
  - On the first edge after reset asserts, the output registers clear: write_enable=0, write_address=0, write_data=0, starvation counter=0.
  - An in-flight registered write is dropped by reset; it never reaches the register file.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - ready is combinational from the valids and the counter. It never depends on the register file.
  - A requester must hold address/data stable while valid && !ready.
- Grant, one per cycle:
  - Default: req0 wins when req0_valid=1. req1 is granted only when req0_valid=0.
  - Both idle: no grant, write_enable=0 next cycle.
- Latency:
  - A granted write appears on write_enable/address/data exactly 1 cycle after acceptance.
  - write_enable is held for exactly 1 cycle per accepted write.
- Register 0:
  - A write with address 0 is accepted (ready=1) but dropped: write_enable stays 0 for that slot.
- Ordering:
  - Writes are emitted in grant order.
  - Two writers targeting the same register in consecutive cycles: the later grant overwrites the earlier one in the register file. No merging.
- busy1 = req1_valid && !req1_ready.
- No internal queue: the block holds at most one write in the output stage.

Optional Feature:
- Macro REGWR_STARVE_GUARD_EN.
- Defined:
  - Counter starve_cnt, width clog2(STARVE_LIMIT+1). It increments on every cycle with busy1=1 and saturates at STARVE_LIMIT.
  - It clears on any req1 grant or when req1_valid=0.
  - When starve_cnt==STARVE_LIMIT and req1_valid=1, req1 is granted and req0_ready=0 for that cycle.
  - The counter then returns to 0.
- Not defined: no counter; strict priority to req0. req1 may starve indefinitely.

Decomposition:
- Shared package/defines:
  - Reuse RegisterBus, RegisterAddressBus, RegisterNumLog2, ZeroWord and WriteEnable from the existing defines header.
  - Add RegWrStarveLimit default 4 and the REGWR_STARVE_GUARD_EN switch.
- No sub-module needed. The single sub-function (starvation counter) stays inline under the macro.

Test Plan:
- Reset hold: reset=1 for 3 cycles with both valids=1 -> both readies=0; write_enable=0 throughout and on the first cycle after release.
- req0 only: req0_valid=1, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle write_enable=1, write_address=5, write_data=0xDEADBEEF, then 0.
- Contention: both valid (r0 addr 3 / 0x11, r1 addr 7 / 0x22), req0 drops after 1 cycle -> cycle 0 grant req0, cycle 1 grant req1; outputs write 3=0x11 then 7=0x22 on consecutive cycles.
- Register 0: req1_valid=1, addr=0, data=0xFFFFFFFF -> req1_ready=1; write_enable stays 0.
- Starvation, with REGWR_STARVE_GUARD_EN and STARVE_LIMIT=4: both valid continuously -> req1 refused 4 cycles, granted on the 5th with req0_ready=0; pattern repeats every 5 cycles. Without the macro, req1 is never granted.
- Reset mid-write: grant req0 (addr 9), assert reset on the next cycle -> write_enable=0 after that edge; register 9 is never written.
